// File: rtl/sdf_pkg.sv
// Mode encoding, 1/sqrt(3) constant and widened saturating helpers for the SDF pipeline.
package sdf_pkg;

    localparam int unsigned WIDE_W = 64;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [1:0] {
        CUBE    = 2'd0,
        OCTA    = 2'd1,
        PLANE_Y = 2'd2,
        RSVD    = 2'd3
    } sdf_mode_e;

    // round(0.5773502692 * 2^16)
    localparam logic [31:0] FP_INV_SQRT3 = 32'd37837;
    localparam real         INV_SQRT3_R  = 0.5773502692;

    function automatic wide_t fp_inv_sqrt3(input int unsigned frac);
        if (frac == 16) return WIDE_W'(FP_INV_SQRT3);
        return WIDE_W'($rtoi(INV_SQRT3_R * (2.0 ** frac) + 0.5));
    endfunction

    // Clamp a widened value into the signed range of a w-bit scalar
    function automatic wide_t fp_sat(input wide_t v, input int unsigned w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic wide_t fp_sub_sat(input wide_t a, input wide_t b, input int unsigned w);
        return fp_sat(a - b, w);
    endfunction

    function automatic wide_t fp_add_sat(input wide_t a, input wide_t b, input int unsigned w);
        return fp_sat(a + b, w);
    endfunction

    function automatic wide_t fp_abs_sat(input wide_t a, input int unsigned w);
        return fp_sat(a[WIDE_W-1] ? -a : a, w);
    endfunction

    function automatic wide_t max3(input wide_t a, input wide_t b, input wide_t c);
        wide_t m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/vector_pkg.sv
// Shared fixed-point scalar and 3-vector types for the ray-march datapath (Q16.16 by default).
package vector_pkg;

    localparam int unsigned FP_W_DEF = 32;
    localparam int unsigned FRAC_DEF = 16;

    typedef logic signed [FP_W_DEF-1:0] fp;

    // x occupies the most significant slice of a packed vec3
    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

endpackage

// File: rtl/sdf_pipe_stage.sv
// Generic valid/stall register slice: loads on advance, holds otherwise; data only captured for valid beats.
module sdf_pipe_stage #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_d;
    logic         valid_q;
    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (advance) begin
            valid_d = in_valid;
            if (in_valid) data_d = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/sdf_prim_pipe.sv
// Three-stage signed-distance evaluator for cube / octahedron / plane-y with valid/ready flow control.
// Define SDF_SAT_EN for saturating arithmetic and the out_sat flag; default build wraps. Assumes FP_W <= 32.
module sdf_prim_pipe
    import vector_pkg::*;
    import sdf_pkg::*;
#(
    parameter int unsigned FP_W  = FP_W_DEF,
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter int unsigned TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3*FP_W-1:0]   in_point,
    input  logic [3*FP_W-1:0]   in_center,
    input  logic [FP_W-1:0]     in_radius,
    input  logic [1:0]          in_mode,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FP_W-1:0]     out_sdf,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err
`ifdef SDF_SAT_EN
    ,
    output logic                out_sat
`endif
);

    typedef logic signed [FP_W-1:0] fp_t;
    typedef logic [TAG_W-1:0]       tag_t;

    localparam wide_t K_INV_SQRT3 = fp_inv_sqrt3(FRAC);

    typedef struct packed {
        fp_t       ax;
        fp_t       ay;
        fp_t       az;
        fp_t       dy;
        fp_t       radius;
        sdf_mode_e mode;
        tag_t      tag;
`ifdef SDF_SAT_EN
        logic      sat;
`endif
    } s1_t;

    typedef struct packed {
        fp_t       r;
        fp_t       h;
        sdf_mode_e mode;
        tag_t      tag;
`ifdef SDF_SAT_EN
        logic      sat;
`endif
    } s2_t;

    typedef struct packed {
        fp_t  sdf;
        tag_t tag;
        logic err;
`ifdef SDF_SAT_EN
        logic sat;
`endif
    } s3_t;

    function automatic wide_t wext(input fp_t x);
        return WIDE_W'(x);
    endfunction

    function automatic fp_t f_sub(input fp_t a, input fp_t b);
`ifdef SDF_SAT_EN
        return FP_W'(fp_sub_sat(wext(a), wext(b), FP_W));
`else
        return a - b;
`endif
    endfunction

    function automatic fp_t f_add(input fp_t a, input fp_t b);
`ifdef SDF_SAT_EN
        return FP_W'(fp_add_sat(wext(a), wext(b), FP_W));
`else
        return a + b;
`endif
    endfunction

    // Wrapping abs leaves the most-negative value unchanged
    function automatic fp_t f_abs(input fp_t a);
`ifdef SDF_SAT_EN
        return FP_W'(fp_abs_sat(wext(a), FP_W));
`else
        return a[FP_W-1] ? -a : a;
`endif
    endfunction

    function automatic wide_t octa_scaled(input fp_t diff);
        return (wext(diff) * K_INV_SQRT3) >>> FRAC;
    endfunction

    function automatic fp_t f_octa(input fp_t diff);
`ifdef SDF_SAT_EN
        return FP_W'(fp_sat(octa_scaled(diff), FP_W));
`else
        return FP_W'(octa_scaled(diff));
`endif
    endfunction

`ifdef SDF_SAT_EN
    function automatic logic clipped(input fp_t res, input wide_t exact);
        return wext(res) != exact;
    endfunction

    function automatic wide_t abs_exact(input fp_t a);
        return a[FP_W-1] ? -wext(a) : wext(a);
    endfunction
`endif

    logic advance;
    logic s1_valid;
    logic s2_valid;
    logic s3_valid;
    s1_t  s1_d;
    s1_t  s1_q;
    s2_t  s2_d;
    s2_t  s2_q;
    s3_t  s3_d;
    s3_t  s3_q;
    fp_t  px, py, pz, cx, cy, cz, dx, dy, dz;
    fp_t  sum_xy, sum_xyz, diff;

    // Whole pipe moves together; a full S3 blocked downstream freezes everything
    assign advance  = !s3_valid || out_ready;
    assign in_ready = advance;

    // S1: offset from centre and per-component magnitude
    always_comb begin
        s1_d = '0;
        px   = in_point[3*FP_W-1 -: FP_W];
        py   = in_point[2*FP_W-1 -: FP_W];
        pz   = in_point[FP_W-1:0];
        cx   = in_center[3*FP_W-1 -: FP_W];
        cy   = in_center[2*FP_W-1 -: FP_W];
        cz   = in_center[FP_W-1:0];
        dx   = f_sub(px, cx);
        dy   = f_sub(py, cy);
        dz   = f_sub(pz, cz);
        s1_d.ax     = f_abs(dx);
        s1_d.ay     = f_abs(dy);
        s1_d.az     = f_abs(dz);
        s1_d.dy     = dy;
        s1_d.radius = in_radius;
        s1_d.mode   = sdf_mode_e'(in_mode);
        s1_d.tag    = in_tag;
`ifdef SDF_SAT_EN
        s1_d.sat = clipped(dx, wext(px) - wext(cx)) || clipped(dy, wext(py) - wext(cy))
                || clipped(dz, wext(pz) - wext(cz)) || clipped(s1_d.ax, abs_exact(dx))
                || clipped(s1_d.ay, abs_exact(dy)) || clipped(s1_d.az, abs_exact(dz));
`endif
    end

    // S2: per-mode reduction to (r, h)
    always_comb begin
        s2_d    = '0;
        sum_xy  = f_add(s1_q.ax, s1_q.ay);
        sum_xyz = f_add(sum_xy, s1_q.az);
        s2_d.mode = s1_q.mode;
        s2_d.tag  = s1_q.tag;
        case (s1_q.mode)
            CUBE: begin
                s2_d.r = FP_W'(max3(wext(s1_q.ax), wext(s1_q.ay), wext(s1_q.az)));
                s2_d.h = s1_q.radius >>> 1;
            end
            OCTA: begin
                s2_d.r = sum_xyz;
                s2_d.h = s1_q.radius;
            end
            PLANE_Y: begin
                s2_d.r = s1_q.dy;
                s2_d.h = s1_q.radius;
            end
            default: ;
        endcase
`ifdef SDF_SAT_EN
        s2_d.sat = s1_q.sat || ((s1_q.mode == OCTA)
                && (clipped(sum_xy, wext(s1_q.ax) + wext(s1_q.ay))
                    || clipped(sum_xyz, wext(sum_xy) + wext(s1_q.az))));
`endif
    end

    // S3: final distance; octahedron scaled by 1/sqrt(3)
    always_comb begin
        s3_d     = '0;
        diff     = f_sub(s2_q.r, s2_q.h);
        s3_d.tag = s2_q.tag;
        case (s2_q.mode)
            CUBE, PLANE_Y: s3_d.sdf = diff;
            OCTA:          s3_d.sdf = f_octa(diff);
            default:       s3_d.err = 1'b1;
        endcase
`ifdef SDF_SAT_EN
        s3_d.sat = (s2_q.mode != RSVD)
                && (s2_q.sat || clipped(diff, wext(s2_q.r) - wext(s2_q.h))
                    || ((s2_q.mode == OCTA) && clipped(s3_d.sdf, octa_scaled(diff))));
`endif
    end

    sdf_pipe_stage #(.W($bits(s1_t))) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .advance   (advance),
        .in_valid  (in_valid),
        .in_data   (s1_d),
        .out_valid (s1_valid),
        .out_data  (s1_q)
    );

    sdf_pipe_stage #(.W($bits(s2_t))) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .advance   (advance),
        .in_valid  (s1_valid),
        .in_data   (s2_d),
        .out_valid (s2_valid),
        .out_data  (s2_q)
    );

    sdf_pipe_stage #(.W($bits(s3_t))) u_s3 (
        .clk       (clk),
        .rst       (rst),
        .advance   (advance),
        .in_valid  (s2_valid),
        .in_data   (s3_d),
        .out_valid (s3_valid),
        .out_data  (s3_q)
    );

    assign out_valid = s3_valid;
    assign out_sdf   = s3_q.sdf;
    assign out_tag   = s3_q.tag;
    assign out_err   = s3_q.err;
`ifdef SDF_SAT_EN
    assign out_sat   = s3_q.sat;
`endif

endmodule

// File: tb/tb_sdf_prim_pipe.sv
// Scoreboard bench for sdf_prim_pipe: directed Q16.16 vectors, stall, reset; honours SDF_SAT_EN.
module tb_sdf_prim_pipe;
    import vector_pkg::*;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned TAG_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    vec3                in_point;
    vec3                in_center;
    logic [FP_W-1:0]    in_radius;
    logic [1:0]         in_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [FP_W-1:0]    out_sdf;
    logic [TAG_W-1:0]   out_tag;
    logic               out_err;
`ifdef SDF_SAT_EN
    logic               out_sat;
`endif

    sdf_prim_pipe #(.FP_W(32), .FRAC(16), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_point  (in_point),
        .in_center (in_center),
        .in_radius (in_radius),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sdf   (out_sdf),
        .out_tag   (out_tag),
        .out_err   (out_err)
`ifdef SDF_SAT_EN
        ,
        .out_sat   (out_sat)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] sdf;
        logic [3:0]  tag;
        logic        err;
        logic        sat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pop = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: pop on every transfer, and check output stability across stalled cycles
    logic        hold_v = 1'b0;
    logic [36:0] hold_bus;
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_valid) check("stall_hold", 64'({out_sdf, out_tag, out_err}), 64'(hold_bus));
            hold_v   = out_valid && !out_ready;
            hold_bus = {out_sdf, out_tag, out_err};
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(out_tag), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    n_pop++;
                    check("sdf", 64'(out_sdf), 64'(e.sdf));
                    check("tag", 64'(out_tag), 64'(e.tag));
                    check("err", 64'(out_err), 64'(e.err));
`ifdef SDF_SAT_EN
                    check("sat", 64'(out_sat), 64'(e.sat));
`endif
                    if (e.acc >= 0) check("latency", 64'(cyc - e.acc), 64'd3);
                end
            end
        end
    end

    function automatic vec3 v3(input fp x, input fp y, input fp z);
        vec3 v;
        v.x = x;
        v.y = y;
        v.z = z;
        return v;
    endfunction

    task automatic send(input vec3 p, input vec3 c, input fp r, input logic [1:0] m,
                        input logic [3:0] t, input logic [31:0] es, input logic ee,
                        input logic esat, input bit chk_lat);
        int budget;
        in_valid  = 1'b1;
        in_point  = p;
        in_center = c;
        in_radius = r;
        in_mode   = m;
        in_tag    = t;
        budget    = 0;
        @(negedge clk);
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{sdf: es, tag: t, err: ee, sat: esat, acc: (chk_lat ? cyc : -1)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((sb.size() != 0 || out_valid) && b < 100) begin
            @(negedge clk);
            b++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    localparam fp ONE  = 32'sh0001_0000;
    localparam fp TWO  = 32'sh0002_0000;
    localparam fp HALF = 32'sh0000_8000;

    bit saw_low;
    int pop_base;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_point  = '0;
        in_center = '0;
        in_radius = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sdf",   64'(out_sdf),   64'd0);
        check("rst_tag",   64'(out_tag),   64'd0);
        check("rst_err",   64'(out_err),   64'd0);
        check("rst_ready", 64'(in_ready),  64'd1);
`ifdef SDF_SAT_EN
        check("rst_sat",   64'(out_sat),   64'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed single transactions, each from an empty pipe
        send(v3(ONE, 32'shFFFD_0000, HALF), v3(0, 0, 0), TWO, 2'd0, 4'h3, 32'h0002_0000, 1'b0, 1'b0, 1'b1);
        drain();
        send(v3(TWO, ONE, ONE), v3(ONE, 0, 0), TWO, 2'd1, 4'h5, 32'h0000_93CD, 1'b0, 1'b0, 1'b1);
        drain();
        send(v3(0, 32'sh0000_4000, 0), v3(0, 0, 0), ONE, 2'd2, 4'h6, 32'hFFFF_4000, 1'b0, 1'b0, 1'b1);
        drain();
        send(v3(ONE, ONE, ONE), v3(0, 0, 0), ONE, 2'd3, 4'h9, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        drain();
        send(v3(0, 0, 0), v3(HALF, HALF, 32'shFFFE_0000), ONE, 2'd0, 4'h1, 32'h0001_8000, 1'b0, 1'b0, 1'b1);
        drain();
        send(v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), ONE, 2'd1, 4'h2, 32'hFFFF_6C33, 1'b0, 1'b0, 1'b1);
        drain();
`ifdef SDF_SAT_EN
        send(v3(32'sh7FFF_0000, 0, 0), v3(32'sh8001_0000, 0, 0), TWO, 2'd0, 4'hA, 32'h7FFE_FFFF, 1'b0, 1'b1, 1'b1);
        drain();
        send(v3(32'sh8000_0000, 0, 0), v3(0, 0, 0), 0, 2'd1, 4'hB, 32'h49E6_7FFF, 1'b0, 1'b1, 1'b1);
        drain();
`else
        send(v3(32'sh7FFF_0000, 0, 0), v3(32'sh8001_0000, 0, 0), TWO, 2'd0, 4'hA, 32'h0001_0000, 1'b0, 1'b0, 1'b1);
        drain();
        send(v3(32'sh8000_0000, 0, 0), v3(0, 0, 0), 0, 2'd1, 4'hB, 32'hB619_8000, 1'b0, 1'b0, 1'b1);
        drain();
`endif

        // Eight back-to-back beats with downstream stalled for cycles 4-7
        pop_base = n_pop;
        saw_low  = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(v3(fp'(i << 16), 0, 0), v3(0, 0, 0), 0, 2'd0, 4'(i), 32'(i << 16), 1'b0, 1'b0, 1'b0);
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    out_ready = !(k >= 4 && k <= 7);
                    @(negedge clk);
                    if (!in_ready) saw_low = 1'b1;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("in_ready_dropped", 64'(saw_low), 64'd1);
        check("stall_count", 64'(n_pop - pop_base), 64'd8);

        // Reset with three transactions in flight
        out_ready = 1'b0;
        send(v3(ONE, 0, 0), v3(0, 0, 0), 0, 2'd0, 4'hC, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        send(v3(ONE, 0, 0), v3(0, 0, 0), 0, 2'd0, 4'hD, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        send(v3(ONE, 0, 0), v3(0, 0, 0), 0, 2'd0, 4'hE, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        check("inflight_valid", 64'(out_valid), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_rst_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(v3(TWO, 0, 0), v3(0, 0, 0), TWO, 2'd0, 4'h7, 32'h0001_0000, 1'b0, 1'b0, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdf_prim_pipe.md
Name: sdf_prim_pipe

Overview:
- Parametrised, pipelined signed-distance evaluator for axis-aligned primitives centred at a programmable point. Successor to the single-cycle cube SDF.
- Per-transaction mode selects cube, octahedron or plane. An ID tag is carried alongside each transaction.
- Full valid/ready handshake, so it can sit between the ray-march step scheduler and the min-combine stage under backpressure.

Parameters:
- FP_W, 32, total width of the signed fixed-point `fp` scalar.
- FRAC, 16, fractional bits of `fp`.
- TAG_W, 4, width of the passthrough transaction tag.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_point  in  3*FP_W  query point (vec3, x/y/z)
- in_center  in  3*FP_W  primitive centre (vec3)
- in_radius  in  FP_W  primitive size (cube edge length / octa radius / plane offset)
- in_mode  in  2  0=cube, 1=octahedron, 2=plane-y, 3=reserved
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_sdf  out  FP_W  signed distance
- out_tag  out  TAG_W  tag of the transaction
- out_err  out  1  set when in_mode was 3 (out_sdf forced to 0)

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). All valid bits clear on reset; out_sdf, out_tag and out_err reset to 0.
- Three-stage pipeline (S1, S2, S3); latency is exactly 3 cycles from acceptance to out_valid when not stalled. Throughput is 1 per cycle.
- Stall rule: advance = !s3_valid || out_ready.
  - in_ready = advance, combinational from out_ready and s3_valid only.
  - All stages hold their contents when !advance.
  - Stage registers load only when advance; a bubble loads valid=0.
- S1:
  - d = point - center, per component.
  - a = |d| per component.
  - Register a, d.y, radius, mode, tag.
- S2 reduction:
  - cube: r = max(a.x, a.y, a.z), h = radius >>> 1 (arithmetic shift).
  - octa: r = a.x + a.y + a.z, h = radius.
  - plane: r = d.y, h = radius.
- S3 result:
  - cube and plane: sdf = r - h.
  - octa: sdf = ((r - h) * K) >>> FRAC, with K = round(0.5773502692 * 2^FRAC) held as a package constant. The product is taken in 2*FP_W bits and truncated.
  - mode 3: sdf = 0, out_err = 1.
- Arithmetic wraps modulo 2^FP_W unless SDF_SAT_EN is defined.
- |most-negative| yields the most-negative value (wrap) without SDF_SAT_EN.
- Output registers are stable while out_valid && !out_ready.
- Reset mid-operation: all in-flight transactions are discarded; no output appears after rst deasserts until new inputs are accepted.

Optional Feature:
- Macro: SDF_SAT_EN.
- Defined:
  - Subtract, add and abs saturate to [-2^(FP_W-1), 2^(FP_W-1)-1].
  - The octa product saturates after the shift.
  - A sticky out_sat flag (extra 1-bit output port, reset 0) pulses with out_valid when any stage saturated for that transaction.
- Undefined: wrapping arithmetic and no out_sat port.

Decomposition:
- Package sdf_pkg (alongside vector_pkg):
  - sdf_mode_e enum (CUBE, OCTA, PLANE_Y, RSVD).
  - Constant FP_INV_SQRT3.
  - Functions fp_abs_sat, fp_add_sat, fp_sub_sat, max3.
- Reuse fp/vec3 from vector_pkg.
- Natural sub-module: sdf_pipe_stage, a generic valid/stall register slice parametrised on payload width and instantiated three times.

Test Plan (Q16.16):
- Cube, point (1.0,-3.0,0.5), centre 0, radius 2.0 -> out_sdf 0x00020000 exactly 3 cycles later, tag echoed.
- Octa, point (2.0,1.0,1.0), centre (1.0,0,0), radius 2.0 -> out_sdf 0x000093CD.
- Plane, point y=0.25, radius 1.0 -> out_sdf 0xFFFF4000 (-0.75); mode 3 -> out_sdf 0, out_err 1.
- 8 back-to-back transactions with out_ready low for cycles 4-7:
  - in_ready drops once the pipe is full.
  - No loss or duplication; tags emerge in order 0..7.
  - Output stays stable while stalled.
- Assert rst with 3 transactions in flight -> out_valid 0 immediately (async); no stale output after release.
- SDF_SAT_EN: cube with point.x = 0x7FFF0000, centre.x = 0x80010000 -> subtraction saturates to 0x7FFFFFFF, out_sat 1. Without the macro, the wrapped value is produced.
